// File: rtl/i2c_reg_sequencer.sv
// i2c_reg_sequencer
// Wishbone master that drives the I2C master core's register interface. It
// programs prescale and enable after reset, then turns one-shot host requests
// (write or read of a slave register) into the core's byte-level command
// sequence. That sequence covers START, address, data, STOP, status polling
// and error recovery.
//
// Ports
//   wb_clk_i, rst_i       clock, asynchronous active-low reset
//   req_valid/req_ready   host request handshake, ready only when idle
//   req_rw                0 = register write, 1 = register read
//   req_dev/req_reg       7-bit slave address, slave register index
//   req_wdata             write data (ignored for reads)
//   resp_valid            one-cycle completion pulse
//   resp_rdata/resp_err   read data / 0 ok, 1 NACK, 2 arb lost, 3 poll timeout
//   m_*                   Wishbone master port to the I2C core
module i2c_reg_sequencer #(
  parameter logic [15:0] PRESCALE   = 16'd199,
  parameter logic [15:0] POLL_LIMIT = 16'd65535
) (
  input  logic       wb_clk_i,
  input  logic       rst_i,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [6:0] req_dev,
  input  logic [7:0] req_reg,
  input  logic [7:0] req_wdata,
  output logic       resp_valid,
  output logic [7:0] resp_rdata,
  output logic [1:0] resp_err,
  output logic       m_cyc_o,
  output logic       m_stb_o,
  output logic       m_we_o,
  output logic [2:0] m_adr_o,
  output logic [7:0] m_dat_o,
  input  logic [7:0] m_dat_i,
  input  logic       m_ack_i
);

  localparam logic [2:0] AdrPrerLo = 3'd0;
  localparam logic [2:0] AdrTxr    = 3'd3;
  localparam logic [2:0] AdrCr     = 3'd4;

  localparam logic [7:0] CmdIack = 8'h01;
  localparam logic [7:0] CmdStop = 8'h40;
  localparam logic [7:0] CmdRdNk = 8'h68;  // RD + STO + NACK

  localparam logic [1:0] ErrOk      = 2'd0;
  localparam logic [1:0] ErrNack    = 2'd1;
  localparam logic [1:0] ErrArb     = 2'd2;
  localparam logic [1:0] ErrTimeout = 2'd3;

  typedef enum logic [2:0] {StInit, StIdle, StBus, StPoll, StClear, StResp} state_e;
  // Which single access StBus is performing.
  typedef enum logic [2:0] {OpTxr, OpCmd, OpRx, OpStop, OpAbort} op_e;

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [1:0]  byte_q, byte_d;
  logic [1:0]  init_idx_q, init_idx_d;
  logic        kick_q;
  logic [15:0] cnt_q, cnt_d, cnt_inc;
  logic        sr_al_q, sr_al_d, sr_rxack_q, sr_rxack_d;
  logic        rw_q, rw_d;
  logic [6:0]  dev_q, dev_d;
  logic [7:0]  reg_q, reg_d, wdata_q, wdata_d;
  logic [1:0]  err_q, err_d;
  logic [7:0]  resp_rdata_q, resp_rdata_d;
  logic [1:0]  resp_err_q, resp_err_d;

  // Access engine
  logic       cyc_q, we_q, done_q;
  logic [2:0] adr_q;
  logic [7:0] dat_q, rdat_q;
  logic       start, go_we;
  logic [2:0] go_adr;
  logic [7:0] go_dat;

  function automatic logic [7:0] txr_val(input logic [1:0] b, input logic rw,
                                         input logic [6:0] dev, input logic [7:0] rg,
                                         input logic [7:0] wd);
    unique case (b)
      2'd0:    txr_val = {dev, 1'b0};
      2'd1:    txr_val = rg;
      default: txr_val = rw ? {dev, 1'b1} : wd;
    endcase
  endfunction

  function automatic logic [7:0] cr_val(input logic [1:0] b, input logic rw);
    unique case (b)
      2'd0:    cr_val = 8'h90;
      2'd1:    cr_val = 8'h10;
      2'd2:    cr_val = rw ? 8'h90 : 8'h50;
      default: cr_val = CmdRdNk;
    endcase
  endfunction

  // done_q marks the idle cycle after an ack; the next access is launched in that
  // same cycle so every access against a one-cycle-ack core takes three cycles.
  always_ff @(posedge wb_clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cyc_q  <= 1'b0;
      we_q   <= 1'b0;
      adr_q  <= 3'd0;
      dat_q  <= 8'd0;
      rdat_q <= 8'd0;
      done_q <= 1'b0;
    end else begin
      done_q <= cyc_q & m_ack_i;
      if (cyc_q && m_ack_i) begin
        cyc_q <= 1'b0;
        if (!we_q) rdat_q <= m_dat_i;
      end else if (start) begin
        cyc_q <= 1'b1;
        adr_q <= go_adr;
        we_q  <= go_we;
        if (go_we) dat_q <= go_dat;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    byte_d       = byte_q;
    init_idx_d   = init_idx_q;
    cnt_d        = cnt_q;
    sr_al_d      = sr_al_q;
    sr_rxack_d   = sr_rxack_q;
    rw_d         = rw_q;
    dev_d        = dev_q;
    reg_d        = reg_q;
    wdata_d      = wdata_q;
    err_d        = err_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    start        = 1'b0;
    go_we        = 1'b0;
    go_adr       = 3'd0;
    go_dat       = 8'd0;
    cnt_inc      = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    unique case (state_q)
      StInit: begin
        if (kick_q) begin
          start  = 1'b1;
          go_we  = 1'b1;
          go_adr = AdrPrerLo;
          go_dat = PRESCALE[7:0];
        end else if (done_q) begin
          if (init_idx_q == 2'd2) begin
            state_d = StIdle;
          end else begin
            init_idx_d = init_idx_q + 2'd1;
            start      = 1'b1;
            go_we      = 1'b1;
            go_adr     = {1'b0, init_idx_d};
            go_dat     = (init_idx_d == 2'd1) ? PRESCALE[15:8] : 8'h80;
          end
        end
      end
      StIdle: begin
        if (req_valid) begin
          rw_d    = req_rw;
          dev_d   = req_dev;
          reg_d   = req_reg;
          wdata_d = req_wdata;
          err_d   = ErrOk;
          byte_d  = 2'd0;
          op_d    = OpTxr;
          state_d = StBus;
          start   = 1'b1;
          go_we   = 1'b1;
          go_adr  = AdrTxr;
          go_dat  = {req_dev, 1'b0};
        end
      end
      StBus: begin
        if (done_q) begin
          unique case (op_q)
            OpTxr: begin
              op_d   = OpCmd;
              start  = 1'b1;
              go_we  = 1'b1;
              go_adr = AdrCr;
              go_dat = cr_val(byte_q, rw_q);
            end
            OpCmd, OpStop: begin
              state_d = StPoll;
              cnt_d   = 16'd0;
              start   = 1'b1;
              go_adr  = AdrCr;
            end
            OpRx: begin
              resp_rdata_d = rdat_q;
              resp_err_d   = ErrOk;
              state_d      = StResp;
            end
            default: begin  // OpAbort: STOP after timeout is not polled
              resp_rdata_d = 8'd0;
              resp_err_d   = err_q;
              state_d      = StResp;
            end
          endcase
        end
      end
      StPoll: begin
        if (done_q) begin
          if (rdat_q[0]) begin
            sr_al_d    = rdat_q[5];
            sr_rxack_d = rdat_q[7];
            state_d    = StClear;
            start      = 1'b1;
            go_we      = 1'b1;
            go_adr     = AdrCr;
            go_dat     = CmdIack;
          end else if (cnt_inc >= POLL_LIMIT) begin
            err_d   = ErrTimeout;
            op_d    = OpAbort;
            state_d = StBus;
            start   = 1'b1;
            go_we   = 1'b1;
            go_adr  = AdrCr;
            go_dat  = CmdStop;
          end else begin
            cnt_d  = cnt_inc;
            start  = 1'b1;
            go_adr = AdrCr;
          end
        end
      end
      StClear: begin
        if (done_q) begin
          if (op_q == OpStop) begin
            resp_rdata_d = 8'd0;
            resp_err_d   = err_q;
            state_d      = StResp;
          end else if (rw_q && byte_q == 2'd3) begin
            // Read byte: RXACK is our own NACK, so only fetch RXR.
            op_d    = OpRx;
            state_d = StBus;
            start   = 1'b1;
            go_adr  = AdrTxr;
          end else if (sr_al_q) begin
            err_d        = ErrArb;
            resp_rdata_d = 8'd0;
            resp_err_d   = ErrArb;
            state_d      = StResp;
          end else if (sr_rxack_q) begin
            err_d   = ErrNack;
            op_d    = OpStop;
            state_d = StBus;
            start   = 1'b1;
            go_we   = 1'b1;
            go_adr  = AdrCr;
            go_dat  = CmdStop;
          end else if (!rw_q && byte_q == 2'd2) begin
            resp_rdata_d = 8'd0;
            resp_err_d   = ErrOk;
            state_d      = StResp;
          end else if (rw_q && byte_q == 2'd2) begin
            // Read command byte has no TXR write.
            byte_d  = 2'd3;
            op_d    = OpCmd;
            state_d = StBus;
            start   = 1'b1;
            go_we   = 1'b1;
            go_adr  = AdrCr;
            go_dat  = CmdRdNk;
          end else begin
            byte_d  = byte_q + 2'd1;
            op_d    = OpTxr;
            state_d = StBus;
            start   = 1'b1;
            go_we   = 1'b1;
            go_adr  = AdrTxr;
            go_dat  = txr_val(byte_d, rw_q, dev_q, reg_q, wdata_q);
          end
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= StInit;
      op_q         <= OpTxr;
      byte_q       <= 2'd0;
      init_idx_q   <= 2'd0;
      kick_q       <= 1'b1;
      cnt_q        <= 16'd0;
      sr_al_q      <= 1'b0;
      sr_rxack_q   <= 1'b0;
      rw_q         <= 1'b0;
      dev_q        <= 7'd0;
      reg_q        <= 8'd0;
      wdata_q      <= 8'd0;
      err_q        <= ErrOk;
      resp_rdata_q <= 8'd0;
      resp_err_q   <= ErrOk;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      byte_q       <= byte_d;
      init_idx_q   <= init_idx_d;
      kick_q       <= 1'b0;
      cnt_q        <= cnt_d;
      sr_al_q      <= sr_al_d;
      sr_rxack_q   <= sr_rxack_d;
      rw_q         <= rw_d;
      dev_q        <= dev_d;
      reg_q        <= reg_d;
      wdata_q      <= wdata_d;
      err_q        <= err_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign m_cyc_o    = cyc_q;
  assign m_stb_o    = cyc_q;
  assign m_we_o     = we_q;
  assign m_adr_o    = adr_q;
  assign m_dat_o    = dat_q;

endmodule
